// File: rtl/processor_core_pkg.sv
// Shared definitions for the multicycle processor core: instruction field
// positions, opcode/aluop encodings, FSM states and exception codes.
package processor_core_pkg;

   // Instruction field positions
   localparam int OPC_LSB   = 27;
   localparam int RD_LSB    = 22;
   localparam int RS_LSB    = 17;
   localparam int RT_LSB    = 12;
   localparam int SHAMT_LSB = 7;
   localparam int ALUOP_LSB = 2;
   localparam int IMM_W     = 17;
   localparam int TGT_W     = 27;

   // Primary opcodes
   localparam logic [4:0] OP_RTYPE = 5'b00000;
   localparam logic [4:0] OP_J     = 5'b00001;
   localparam logic [4:0] OP_BNE   = 5'b00010;
   localparam logic [4:0] OP_JAL   = 5'b00011;
   localparam logic [4:0] OP_JR    = 5'b00100;
   localparam logic [4:0] OP_ADDI  = 5'b00101;
   localparam logic [4:0] OP_BLT   = 5'b00110;
   localparam logic [4:0] OP_SW    = 5'b00111;
   localparam logic [4:0] OP_LW    = 5'b01000;
   localparam logic [4:0] OP_SETX  = 5'b10101;
   localparam logic [4:0] OP_BEX   = 5'b10110;

   // R-type aluop encodings
   localparam logic [4:0] ALU_ADD = 5'b00000;
   localparam logic [4:0] ALU_SUB = 5'b00001;
   localparam logic [4:0] ALU_AND = 5'b00010;
   localparam logic [4:0] ALU_OR  = 5'b00011;
   localparam logic [4:0] ALU_SLL = 5'b00100;
   localparam logic [4:0] ALU_SRA = 5'b00101;

   // Architectural register roles
   localparam logic [4:0] REG_ZERO   = 5'd0;
   localparam logic [4:0] REG_STATUS = 5'd30;
   localparam logic [4:0] REG_LINK   = 5'd31;

   // Values written to the status register on signed overflow
   localparam logic [31:0] EXC_ADD  = 32'd1;
   localparam logic [31:0] EXC_ADDI = 32'd2;
   localparam logic [31:0] EXC_SUB  = 32'd3;

   typedef enum logic [1:0] {S_FETCH, S_DECODE, S_EXEC, S_WB} state_e;

   typedef enum logic [2:0] {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLL, FN_SRA} alu_fn_e;

   function automatic logic [4:0] f_opcode(input logic [31:0] ins);
      return ins[OPC_LSB +: 5];
   endfunction

   function automatic logic [4:0] f_rd(input logic [31:0] ins);
      return ins[RD_LSB +: 5];
   endfunction

   function automatic logic [4:0] f_rs(input logic [31:0] ins);
      return ins[RS_LSB +: 5];
   endfunction

   function automatic logic [4:0] f_rt(input logic [31:0] ins);
      return ins[RT_LSB +: 5];
   endfunction

   function automatic logic [4:0] f_shamt(input logic [31:0] ins);
      return ins[SHAMT_LSB +: 5];
   endfunction

   function automatic logic [4:0] f_aluop(input logic [31:0] ins);
      return ins[ALUOP_LSB +: 5];
   endfunction

   function automatic logic [31:0] f_imm(input logic [31:0] ins);
      return {{(32-IMM_W){ins[IMM_W-1]}}, ins[IMM_W-1:0]};
   endfunction

   function automatic logic [31:0] f_target(input logic [31:0] ins);
      return {{(32-TGT_W){1'b0}}, ins[TGT_W-1:0]};
   endfunction

endpackage

// File: rtl/processor_core_alu.sv
// 32-bit ALU: add/sub/and/or/sll/sra with signed-overflow flag, plus
// not-equal and signed less-than compare flags on the raw operands.
module processor_core_alu
   import processor_core_pkg::*;
(
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   input  alu_fn_e     fn_i,
   input  logic [4:0]  shamt_i,
   output logic [31:0] result_o,
   output logic        overflow_o,
   output logic        ne_o,
   output logic        lt_o
);

   logic [31:0] sum;
   logic [31:0] diff;

   assign sum  = a_i + b_i;
   assign diff = a_i - b_i;

   // Result and overflow selection by function
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no latch is inferred.
      result_o   = 32'd0;
      overflow_o = 1'b0;
      case (fn_i)
         FN_ADD: begin
            result_o   = sum;
            overflow_o = (a_i[31] == b_i[31]) && (sum[31] != a_i[31]);
         end
         FN_SUB: begin
            result_o   = diff;
            overflow_o = (a_i[31] != b_i[31]) && (diff[31] != a_i[31]);
         end
         FN_AND:  result_o = a_i & b_i;
         FN_OR:   result_o = a_i | b_i;
         FN_SLL:  result_o = a_i << shamt_i;
         FN_SRA:  result_o = $signed(a_i) >>> shamt_i;
         default: result_o = 32'd0;
      endcase
   end

   assign ne_o = (a_i != b_i);
   assign lt_o = ($signed(a_i) < $signed(b_i));

endmodule

// File: rtl/processor_core.sv
// Multicycle processor core: every instruction takes FETCH, DECODE, EXEC, WB.
// Register file, instruction ROM and data RAM live outside this block.
module processor_core
   import processor_core_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   output logic [31:0] address_imem,
   input  logic [31:0] q_imem,
   output logic        ctrl_writeEnable,
   output logic [4:0]  ctrl_writeReg,
   output logic [4:0]  ctrl_readRegA,
   output logic [4:0]  ctrl_readRegB,
   output logic [31:0] data_writeReg,
   input  logic [31:0] data_readRegA,
   input  logic [31:0] data_readRegB,
   output logic        wren,
   output logic [31:0] address_dmem,
   output logic [31:0] data,
   input  logic [31:0] q_dmem
);

   state_e      state_q;
   logic [31:0] pc_q, pc_d;
   logic [31:0] ir_q, a_q, b_q, result_q;
   logic        ovf_q;

   logic [4:0]  opc, aluop;
   logic [31:0] imm, target;
   logic        rtype_ok;
   logic [4:0]  rd_a_idx, rd_b_idx;

   alu_fn_e     alu_fn;
   logic [31:0] alu_a, alu_b, alu_result;
   logic        alu_ovf, alu_ne, alu_lt;

   logic        wb_en;
   logic [4:0]  wb_idx;
   logic [31:0] wb_data;

   assign opc      = f_opcode(ir_q);
   assign aluop    = f_aluop(ir_q);
   assign imm      = f_imm(ir_q);
   assign target   = f_target(ir_q);
   assign rtype_ok = (aluop <= ALU_SRA);

   // Register-file read indices, decoded straight from the ROM word during DECODE
   always_comb begin
      rd_a_idx = f_rs(q_imem);
      rd_b_idx = REG_ZERO;
      case (f_opcode(q_imem))
         OP_SETX, OP_J, OP_JAL:         rd_a_idx = REG_ZERO;
         OP_BEX:                        rd_a_idx = REG_STATUS;
         default:                       rd_a_idx = f_rs(q_imem);
      endcase
      case (f_opcode(q_imem))
         OP_RTYPE:                      rd_b_idx = f_rt(q_imem);
         OP_SW, OP_BNE, OP_BLT, OP_JR:  rd_b_idx = f_rd(q_imem);
         default:                       rd_b_idx = REG_ZERO;
      endcase
   end

   // ALU operand and function selection; blt swaps operands so lt means rd < rs
   always_comb begin
      alu_fn = FN_ADD;
      alu_a  = a_q;
      alu_b  = imm;
      if (opc == OP_RTYPE) begin
         alu_b = b_q;
         case (aluop)
            ALU_SUB: alu_fn = FN_SUB;
            ALU_AND: alu_fn = FN_AND;
            ALU_OR:  alu_fn = FN_OR;
            ALU_SLL: alu_fn = FN_SLL;
            ALU_SRA: alu_fn = FN_SRA;
            default: alu_fn = FN_ADD;
         endcase
      end else if (opc == OP_BNE) begin
         alu_b = b_q;
      end else if (opc == OP_BLT) begin
         alu_a = b_q;
         alu_b = a_q;
      end
   end

   processor_core_alu u_alu (
      .a_i        (alu_a),
      .b_i        (alu_b),
      .fn_i       (alu_fn),
      .shamt_i    (f_shamt(ir_q)),
      .result_o   (alu_result),
      .overflow_o (alu_ovf),
      .ne_o       (alu_ne),
      .lt_o       (alu_lt)
   );

   // Write-back destination and data; overflow redirects the write to r30
   always_comb begin
      wb_en   = 1'b0;
      wb_idx  = REG_ZERO;
      wb_data = 32'd0;
      case (opc)
         OP_RTYPE: if (rtype_ok) begin
            wb_en = 1'b1;
            if (ovf_q) begin
               wb_idx  = REG_STATUS;
               wb_data = (aluop == ALU_SUB) ? EXC_SUB : EXC_ADD;
            end else begin
               wb_idx  = f_rd(ir_q);
               wb_data = result_q;
            end
         end
         OP_ADDI: begin
            wb_en   = 1'b1;
            wb_idx  = ovf_q ? REG_STATUS : f_rd(ir_q);
            wb_data = ovf_q ? EXC_ADDI : result_q;
         end
         OP_LW:   begin wb_en = 1'b1; wb_idx = f_rd(ir_q); wb_data = q_dmem;      end
         OP_JAL:  begin wb_en = 1'b1; wb_idx = REG_LINK;   wb_data = pc_q + 32'd1; end
         OP_SETX: begin wb_en = 1'b1; wb_idx = REG_STATUS; wb_data = target;       end
         default: wb_en = 1'b0;
      endcase
      if (wb_idx == REG_ZERO) wb_en = 1'b0;
   end

   // Next PC, applied at the end of WB; ALU compare flags still see held A/B
   always_comb begin
      pc_d = pc_q + 32'd1;
      case (opc)
         OP_J, OP_JAL: pc_d = target;
         OP_JR:        pc_d = b_q;
         OP_BNE:       if (alu_ne) pc_d = pc_q + 32'd1 + imm;
         OP_BLT:       if (alu_lt) pc_d = pc_q + 32'd1 + imm;
         OP_BEX:       if (a_q != 32'd0) pc_d = target;
         default:      pc_d = pc_q + 32'd1;
      endcase
   end

   // Per-state output decode; reset masks every write strobe in its own cycle
   always_comb begin
      address_imem     = pc_q;
      ctrl_readRegA    = REG_ZERO;
      ctrl_readRegB    = REG_ZERO;
      ctrl_writeEnable = 1'b0;
      ctrl_writeReg    = REG_ZERO;
      data_writeReg    = 32'd0;
      wren             = 1'b0;
      address_dmem     = 32'd0;
      data             = 32'd0;
      if (!reset) begin
         case (state_q)
            S_DECODE: begin
               ctrl_readRegA = rd_a_idx;
               ctrl_readRegB = rd_b_idx;
            end
            S_EXEC: if (opc == OP_LW || opc == OP_SW) begin
               address_dmem = alu_result;
               if (opc == OP_SW) begin
                  wren = 1'b1;
                  data = b_q;
               end
            end
            S_WB: if (wb_en) begin
               ctrl_writeEnable = 1'b1;
               ctrl_writeReg    = wb_idx;
               data_writeReg    = wb_data;
            end
            default: ;
         endcase
      end
   end

   // Instruction sequencer: PC, IR, operand latches and the four-state FSM
   always_ff @(posedge clock) begin
      // NOTE: reset is synchronous, so it is tested inside the clocked block; state uses <= only.
      if (reset) begin
         state_q  <= S_FETCH;
         pc_q     <= 32'd0;
         ir_q     <= 32'd0;
         a_q      <= 32'd0;
         b_q      <= 32'd0;
         result_q <= 32'd0;
         ovf_q    <= 1'b0;
      end else begin
         case (state_q)
            S_FETCH: state_q <= S_DECODE;
            S_DECODE: begin
               ir_q    <= q_imem;
               a_q     <= data_readRegA;
               b_q     <= data_readRegB;
               state_q <= S_EXEC;
            end
            S_EXEC: begin
               result_q <= alu_result;
               ovf_q    <= alu_ovf;
               state_q  <= S_WB;
            end
            default: begin
               pc_q    <= pc_d;
               state_q <= S_FETCH;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_processor_core.sv
// Bench for processor_core: external ROM/RAM/register file, an ISA-level
// reference model that queues expected fetches and writes, and a monitor
// that pops and compares whenever the core presents an event.
module tb_processor_core;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] address_imem, q_imem, data_writeReg, data_readRegA, data_readRegB;
   logic [31:0] address_dmem, data, q_dmem;
   logic        ctrl_writeEnable, wren;
   logic [4:0]  ctrl_writeReg, ctrl_readRegA, ctrl_readRegB;

   processor_core dut (
      .clock            (clock),
      .reset            (reset),
      .address_imem     (address_imem),
      .q_imem           (q_imem),
      .ctrl_writeEnable (ctrl_writeEnable),
      .ctrl_writeReg    (ctrl_writeReg),
      .ctrl_readRegA    (ctrl_readRegA),
      .ctrl_readRegB    (ctrl_readRegB),
      .data_writeReg    (data_writeReg),
      .data_readRegA    (data_readRegA),
      .data_readRegB    (data_readRegB),
      .wren             (wren),
      .address_dmem     (address_dmem),
      .data             (data),
      .q_dmem           (q_dmem)
   );

   always #5 clock = ~clock;

   // ---------------- environment: ROM, RAM, register file ----------------
   logic [31:0] rom      [64];
   logic [31:0] rf       [32];
   logic [31:0] ram      [4096];
   logic [31:0] init_rf  [32];
   logic [31:0] init_ram [4096];
   logic        load_req = 1'b0;

   assign data_readRegA = rf[ctrl_readRegA];
   assign data_readRegB = rf[ctrl_readRegB];

   always @(posedge clock) begin
      q_imem <= rom[address_imem[5:0]];
      q_dmem <= ram[address_dmem[11:0]];
      if (load_req) begin
         rf  <= init_rf;
         ram <= init_ram;
      end else begin
         if (wren) ram[address_dmem[11:0]] <= data;
         if (ctrl_writeEnable && ctrl_writeReg != 5'd0) rf[ctrl_writeReg] <= data_writeReg;
      end
   end

   // ---------------- scoreboard ----------------
   typedef struct {
      int          cyc;
      logic [31:0] a;
      logic [31:0] d;
   } ev_t;

   ev_t exp_fetch[$];
   ev_t exp_reg[$];
   ev_t exp_mem[$];

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endtask

   // Monitor: cycle 1 is the first cycle with reset low
   int cyc = 0;
   always @(negedge clock) begin
      ev_t e;
      if (reset) begin
         cyc = 0;
         check("reset_quiet", {30'd0, wren, ctrl_writeEnable}, 32'd0);
      end else begin
         cyc++;
         if (cyc % 4 == 1 && exp_fetch.size() != 0) begin
            e = exp_fetch.pop_front();
            check("fetch_pc", address_imem, e.a);
         end
         if (wren) begin
            if (exp_mem.size() == 0) check("unexpected_mem_write", 32'd1, 32'd0);
            else begin
               e = exp_mem.pop_front();
               check("mem_cycle", cyc, e.cyc);
               check("mem_addr", address_dmem, e.a);
               check("mem_data", data, e.d);
            end
         end
         if (ctrl_writeEnable) begin
            if (exp_reg.size() == 0) check("unexpected_reg_write", 32'd1, 32'd0);
            else begin
               e = exp_reg.pop_front();
               check("wb_cycle", cyc, e.cyc);
               check("wb_reg", {27'd0, ctrl_writeReg}, e.a);
               check("wb_data", data_writeReg, e.d);
            end
         end
      end
   end

   // ---------------- ISA-level reference model ----------------
   localparam longint S_MAX = 64'sh7FFF_FFFF;
   localparam longint S_MIN = -64'sh8000_0000;

   logic [31:0] m_rf  [32];
   logic [31:0] m_ram [4096];

   function automatic bit ovf(input longint s);
      return (s > S_MAX) || (s < S_MIN);
   endfunction

   task automatic model_run(input int n);
      logic [31:0] pc, nxt, ins, a, b, imm, tgt, addr, wval;
      logic [4:0]  op, rd, rs, rt, sh, fn, wr;
      longint      s;
      bit          do_wr;
      m_rf  = init_rf;
      m_ram = init_ram;
      pc    = 32'd0;
      for (int i = 0; i < n; i++) begin
         ins = rom[pc[5:0]];
         op = ins[31:27]; rd = ins[26:22]; rs = ins[21:17]; rt = ins[16:12];
         sh = ins[11:7];  fn = ins[6:2];
         imm = {{15{ins[16]}}, ins[16:0]};
         tgt = {5'd0, ins[26:0]};
         exp_fetch.push_back(ev_t'{4*i+1, pc, 32'd0});
         do_wr = 1'b0; wr = rd; wval = 32'd0; nxt = pc + 32'd1;
         a = m_rf[rs]; b = m_rf[rt];
         case (op)
            5'b00000: begin
               do_wr = 1'b1;
               case (fn)
                  5'd0: begin
                     s = longint'($signed(a)) + longint'($signed(b));
                     if (ovf(s)) begin wr = 5'd30; wval = 32'd1; end else wval = a + b;
                  end
                  5'd1: begin
                     s = longint'($signed(a)) - longint'($signed(b));
                     if (ovf(s)) begin wr = 5'd30; wval = 32'd3; end else wval = a - b;
                  end
                  5'd2: wval = a & b;
                  5'd3: wval = a | b;
                  5'd4: wval = a << sh;
                  5'd5: wval = $signed(a) >>> sh;
                  default: do_wr = 1'b0;
               endcase
            end
            5'b00101: begin
               do_wr = 1'b1;
               s = longint'($signed(a)) + longint'($signed(imm));
               if (ovf(s)) begin wr = 5'd30; wval = 32'd2; end else wval = a + imm;
            end
            5'b00111: begin
               addr = a + imm;
               exp_mem.push_back(ev_t'{4*i+3, addr, m_rf[rd]});
               m_ram[addr[11:0]] = m_rf[rd];
            end
            5'b01000: begin
               addr = a + imm;
               do_wr = 1'b1; wval = m_ram[addr[11:0]];
            end
            5'b00001: nxt = tgt;
            5'b00011: begin do_wr = 1'b1; wr = 5'd31; wval = pc + 32'd1; nxt = tgt; end
            5'b00100: nxt = m_rf[rd];
            5'b00010: if (m_rf[rd] != m_rf[rs]) nxt = pc + 32'd1 + imm;
            5'b00110: if ($signed(m_rf[rd]) < $signed(m_rf[rs])) nxt = pc + 32'd1 + imm;
            5'b10110: if (m_rf[30] != 32'd0) nxt = tgt;
            5'b10101: begin do_wr = 1'b1; wr = 5'd30; wval = tgt; end
            default: ;
         endcase
         if (do_wr && wr != 5'd0) begin
            exp_reg.push_back(ev_t'{4*i+4, {27'd0, wr}, wval});
            m_rf[wr] = wval;
         end
         pc = nxt;
      end
   endtask

   // ---------------- stimulus helpers ----------------
   function automatic logic [31:0] enc_r(input logic [4:0] rd, rs, rt, sh, fn);
      return {5'b00000, rd, rs, rt, sh, fn, 2'b00};
   endfunction

   function automatic logic [31:0] enc_i(input logic [4:0] op, rd, rs, input logic [16:0] imm);
      return {op, rd, rs, imm};
   endfunction

   function automatic logic [31:0] enc_j(input logic [4:0] op, input logic [26:0] t);
      return {op, t};
   endfunction

   function automatic logic [4:0] rr();
      return 5'($urandom_range(0, 31));
   endfunction

   function automatic logic [31:0] rand_val();
      case ($urandom_range(0, 5))
         0:       return 32'h7FFF_FFFF;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'($urandom_range(0, 20));
         4:       return 32'd1;
         default: return $urandom;
      endcase
   endfunction

   function automatic logic [16:0] rand_off();
      int off;
      off = $urandom_range(0, 12);
      off = off - 6;
      return off[16:0];
   endfunction

   task automatic clear_env();
      for (int k = 0; k < 64; k++)   rom[k] = 32'd0;
      for (int k = 0; k < 32; k++)   init_rf[k] = 32'd0;
      for (int k = 0; k < 4096; k++) init_ram[k] = 32'd0;
   endtask

   task automatic gen_random();
      clear_env();
      for (int k = 1; k < 32; k++) init_rf[k] = rand_val();
      for (int k = 0; k < 64; k++) init_ram[k] = $urandom;
      for (int k = 0; k < 64; k++) begin
         case ($urandom_range(0, 11))
            0, 1, 2: rom[k] = enc_r(rr(), rr(), rr(), rr(), 5'($urandom_range(0, 7)));
            3:  rom[k] = enc_i(5'b00101, rr(), rr(), 17'($urandom));
            4:  rom[k] = enc_i(5'b00111, rr(), rr(), 17'($urandom_range(0, 4095)));
            5:  rom[k] = enc_i(5'b01000, rr(), rr(), 17'($urandom_range(0, 4095)));
            6:  rom[k] = enc_i(5'b00010, rr(), rr(), rand_off());
            7:  rom[k] = enc_i(5'b00110, rr(), rr(), rand_off());
            8:  rom[k] = enc_j($urandom_range(0, 1) ? 5'b00001 : 5'b00011, 27'($urandom_range(0, 63)));
            9:  rom[k] = enc_i(5'b00100, rr(), rr(), 17'd0);
            10: rom[k] = enc_j($urandom_range(0, 1) ? 5'b10101 : 5'b10110, 27'($urandom_range(0, 63)));
            default: rom[k] = $urandom;
         endcase
      end
   endtask

   task automatic drain_check();
      check("pending_fetch", exp_fetch.size(), 32'd0);
      check("pending_reg",   exp_reg.size(),   32'd0);
      check("pending_mem",   exp_mem.size(),   32'd0);
      exp_fetch.delete(); exp_reg.delete(); exp_mem.delete();
   endtask

   // Reset, load environment, run n instructions, then hold reset again
   task automatic run_program(input int n);
      @(posedge clock); #1 reset = 1'b1; load_req = 1'b1;
      @(posedge clock); #1 load_req = 1'b0;
      model_run(n);
      reset = 1'b0;
      repeat (4*n) @(posedge clock);
      #1 reset = 1'b1;
      @(posedge clock); #1;
      drain_check();
   endtask

   // ---------------- test sequence ----------------
   initial begin
      clear_env();
      @(posedge clock); #1;
      check("reset_pc", address_imem, 32'd0);

      // Straight-line arithmetic: r3 = 12, written in WB of cycle 12
      clear_env();
      rom[0] = enc_i(5'b00101, 5'd1, 5'd0, 17'd5);
      rom[1] = enc_i(5'b00101, 5'd2, 5'd0, 17'd7);
      rom[2] = enc_r(5'd3, 5'd1, 5'd2, 5'd0, 5'd0);
      run_program(3);
      check("r3_sum", rf[3], 32'd12);

      // Overflow on add, addi and sub redirects to r30 with codes 1, 2, 3
      clear_env();
      init_rf[1] = 32'h7FFF_FFFF;
      init_rf[5] = 32'h8000_0000;
      rom[0] = enc_i(5'b00101, 5'd2, 5'd0, 17'd1);
      rom[1] = enc_r(5'd3, 5'd1, 5'd2, 5'd0, 5'd0);
      rom[2] = enc_i(5'b00101, 5'd6, 5'd1, 17'd1);
      rom[3] = enc_r(5'd4, 5'd5, 5'd2, 5'd0, 5'd1);
      run_program(4);
      check("ovf_r30", rf[30], 32'd3);
      check("ovf_r3_kept", rf[3], 32'd0);
      check("ovf_r6_kept", rf[6], 32'd0);
      check("ovf_r4_kept", rf[4], 32'd0);

      // Store then load through the external RAM
      clear_env();
      init_rf[1] = 32'd9;
      rom[0] = enc_i(5'b00111, 5'd1, 5'd0, 17'd4);
      rom[1] = enc_i(5'b01000, 5'd4, 5'd0, 17'd4);
      run_program(2);
      check("ram4", ram[4], 32'd9);
      check("r4_load", rf[4], 32'd9);

      // bne skip, blt taken, jal/jr round trip
      clear_env();
      init_rf[1] = 32'd5; init_rf[2] = 32'd6;
      init_rf[5] = 32'hFFFF_FFFF; init_rf[6] = 32'd1;
      rom[0]  = enc_i(5'b00010, 5'd1, 5'd2, 17'd2);
      rom[1]  = enc_i(5'b00101, 5'd7, 5'd0, 17'd1);
      rom[2]  = enc_i(5'b00101, 5'd7, 5'd0, 17'd2);
      rom[3]  = enc_i(5'b00110, 5'd5, 5'd6, 17'd1);
      rom[4]  = enc_i(5'b00101, 5'd8, 5'd0, 17'd1);
      rom[5]  = enc_j(5'b00011, 27'd10);
      rom[6]  = enc_i(5'b00101, 5'd9, 5'd0, 17'd9);
      rom[10] = enc_i(5'b00100, 5'd31, 5'd0, 17'd0);
      run_program(7);
      check("r31_link", rf[31], 32'd6);
      check("r7_skipped", rf[7], 32'd0);
      check("r8_skipped", rf[8], 32'd0);
      check("r9_after_jr", rf[9], 32'd9);

      // setx/bex taken, then bex with r30 = 0 falls through
      clear_env();
      rom[0]  = enc_j(5'b10101, 27'd3);
      rom[1]  = enc_j(5'b10110, 27'd20);
      rom[20] = enc_j(5'b10101, 27'd0);
      rom[21] = enc_j(5'b10110, 27'd40);
      rom[22] = enc_i(5'b00101, 5'd1, 5'd0, 17'd1);
      run_program(5);
      check("r30_cleared", rf[30], 32'd0);
      check("r1_fallthru", rf[1], 32'd1);

      // Reset during EXEC of a store: no write, restart from address 0
      clear_env();
      init_rf[1] = 32'd9;
      rom[0] = enc_i(5'b00101, 5'd2, 5'd0, 17'd1);
      rom[1] = enc_i(5'b00111, 5'd1, 5'd0, 17'd4);
      @(posedge clock); #1 reset = 1'b1; load_req = 1'b1;
      @(posedge clock); #1 load_req = 1'b0;
      model_run(1);
      exp_fetch.push_back(ev_t'{5, 32'd1, 32'd0});
      reset = 1'b0;
      repeat (6) @(posedge clock);
      #1 reset = 1'b1;
      exp_fetch.push_back(ev_t'{1, 32'd0, 32'd0});
      @(posedge clock); #1 reset = 1'b0;
      @(posedge clock); #1 reset = 1'b1;
      @(posedge clock); #1;
      check("abort_ram4", ram[4], 32'd0);
      check("abort_r2", rf[2], 32'd1);
      drain_check();

      // Randomized programs against the reference model
      for (int p = 0; p < 24; p++) begin
         gen_random();
         run_program(80);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
